// File: rtl/regfile_gen_pkg.sv
// +------------------------------------------------------------------+
// | regfile_gen_pkg -- shared state encodings and default parameters  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package regfile_gen_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NRD      = 2;
  localparam bit DEF_ZERO_REG = 1'b1;
  localparam bit DEF_BYPASS   = 1'b1;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_clr_fsm.sv
// +------------------------------------------------------------------+
// | regfile_clr_fsm -- clear-sweep controller and clr_ptr counter     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module regfile_clr_fsm
  import regfile_gen_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              busy_q;

  // Reset lands in CLEAR so the array, which has no reset of its own, is swept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr_req) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST_PTR) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = clr_ptr_q;

endmodule

`default_nettype wire

// File: rtl/regfile_gen.sv
// +------------------------------------------------------------------+
// | regfile_gen -- byte-masked multi-read register file with clear    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module regfile_gen
  import regfile_gen_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = DEF_NRD,
  parameter bit ZERO_REG = DEF_ZERO_REG,
  parameter bit BYPASS   = DEF_BYPASS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  clr_req,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0]     test_addr,
  output logic [DATA_W-1:0]     test_data,
  output logic                  busy,
  output logic                  wr_drop
);

  localparam int DEPTH = int'(depth_of(ADDR_W));
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;
  logic              wr_zero;
  logic              wr_eff;
  logic              wr_drop_d;
  logic              wr_drop_q;
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] wmerge;

  regfile_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // clr_req beats a same-cycle write; writes under reset vanish without a drop pulse.
  assign wr_ok     = wen & ~rst & ~busy & ~clr_req;
  assign wr_zero   = ZERO_REG && (waddr == '0);
  assign wr_eff    = wr_ok & ~wr_zero;
  assign wr_drop_d = wen & ~rst & (busy | clr_req);

  for (genvar b = 0; b < NB; b++) begin : g_mask
    assign wmask[b*8 +: 8] = {8{wstrb[b]}};
  end

  assign wmerge = (mem_q[waddr] & ~wmask) | (wdata & wmask);

  // Sweep and host write are mutually exclusive since a write needs an idle FSM.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_eff) begin
      mem_q[waddr] <= wmerge;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= wr_drop_d;
    end
  end

  assign wr_drop = wr_drop_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = mem_q[ra];
      if (BYPASS && wr_eff && (ra == waddr)) begin
        rd = wmerge;
      end
      if (ZERO_REG && (ra == '0)) begin
        rd = '0;
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = rd;
  end

  assign test_data = (ZERO_REG && (test_addr == '0)) ? '0 : mem_q[test_addr];

endmodule

`default_nettype wire

// File: tb/tb_regfile_gen.sv
// +------------------------------------------------------------------+
// | tb_regfile_gen -- directed self-checking bench for regfile_gen    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_regfile_gen;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wen;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              clr_req;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic [AW-1:0]     test_addr;
  logic [DW-1:0]     test_data;
  logic              busy;
  logic              wr_drop;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt;

  always #5 clk = ~clk;

  regfile_gen #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NRD      (NRD),
    .ZERO_REG (1'b1),
    .BYPASS   (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .clr_req   (clr_req),
    .raddr     (raddr),
    .rdata     (rdata),
    .test_addr (test_addr),
    .test_data (test_data),
    .busy      (busy),
    .wr_drop   (wr_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy();
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
    clr_req = 1'b0; raddr = '0; test_addr = '0;

    // Post-reset sweep
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_wr_drop", 32'(wr_drop), 32'd0);
    count_busy();
    chk("rst_sweep_len", cnt, 32'd32);
    for (int a = 0; a < 32; a++) begin
      test_addr = AW'(a);
      #1;
      chk($sformatf("post_rst_zero_%0d", a), test_data, 32'h0);
    end

    // Byte-masked writes
    wen = 1'b1; waddr = 5'd5; wdata = 32'h0000_003F; wstrb = 4'hF;
    tick();
    wdata = 32'hAABB_CCDD; wstrb = 4'b0100;
    tick();
    wen = 1'b0; test_addr = 5'd5;
    #1;
    chk("bytemask_e5", test_data, 32'h00BB_003F);
    chk("bytemask_no_drop", 32'(wr_drop), 32'd0);

    // Same-cycle bypass; test_data still shows stored value
    raddr = {5'd6, 5'd5};
    wen = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; wstrb = 4'hF;
    #1;
    chk("bypass_p0", rdata[31:0], 32'h1234_5678);
    chk("bypass_test_old", test_data, 32'h00BB_003F);
    chk("bypass_p1_other", rdata[63:32], 32'h0);
    tick();
    wen = 1'b0;
    #1;
    chk("bypass_written", test_data, 32'h1234_5678);
    raddr = {5'd5, 5'd5};
    wen = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'b0001;
    #1;
    chk("bypass_partial_p0", rdata[31:0], 32'h1234_56FF);
    chk("bypass_partial_p1", rdata[63:32], 32'h1234_56FF);
    tick();
    wen = 1'b0;
    #1;
    chk("partial_stored", test_data, 32'h1234_56FF);

    // Zero register
    raddr = {5'd0, 5'd0}; test_addr = 5'd0;
    wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    #1;
    chk("zero_bypass_p0", rdata[31:0], 32'h0);
    chk("zero_bypass_p1", rdata[63:32], 32'h0);
    tick();
    wen = 1'b0;
    #1;
    chk("zero_p0", rdata[31:0], 32'h0);
    chk("zero_test", test_data, 32'h0);
    chk("zero_no_drop", 32'(wr_drop), 32'd0);

    // Second read port, partial strobe on a high entry
    wen = 1'b1; waddr = 5'd31; wdata = 32'hA5A5_A5A5; wstrb = 4'b1010;
    tick();
    wen = 1'b0; raddr = {5'd31, 5'd5};
    #1;
    chk("p1_e31", rdata[63:32], 32'hA500_A500);
    chk("p0_e5", rdata[31:0], 32'h1234_56FF);

    // Write racing a clear request, then a write during the sweep
    wen = 1'b1; waddr = 5'd7; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    tick();
    test_addr = 5'd7;
    clr_req = 1'b1; wdata = 32'h1111_1111;
    #1;
    chk("pre_clr_e7", test_data, 32'hCAFE_F00D);
    tick();
    clr_req = 1'b0; wen = 1'b0;
    chk("clr_drop", 32'(wr_drop), 32'd1);
    chk("clr_busy", 32'(busy), 32'd1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 2) begin
        chk("mid_sweep_e7_old", test_data, 32'hCAFE_F00D);
        wen = 1'b1; waddr = 5'd9; wdata = 32'h0000_0099; clr_req = 1'b1;
      end
      if (cnt == 3) begin
        chk("sweep_write_drop", 32'(wr_drop), 32'd1);
        wen = 1'b0; clr_req = 1'b0;
      end
      tick();
    end
    chk("clr_sweep_len", cnt, 32'd32);
    chk("post_clr_e7", test_data, 32'h0);
    chk("post_clr_no_drop", 32'(wr_drop), 32'd0);
    test_addr = 5'd9;
    #1;
    chk("post_clr_e9", test_data, 32'h0);

    // Reset mid-sweep restarts from entry 0; write under reset gives no drop
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1; wen = 1'b1; waddr = 5'd3; wdata = 32'h3333_3333; wstrb = 4'hF;
    tick();
    rst = 1'b0; wen = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_no_drop", 32'(wr_drop), 32'd0);
    count_busy();
    chk("midrst_sweep_len", cnt, 32'd32);
    test_addr = 5'd3;
    #1;
    chk("midrst_e3", test_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
